avln_framer: RTL and testbench
==============================

# avln_framer

Packet-framing repair stage sitting directly downstream of the line-delay FIFO on the avln_st stream. Enforces well-formed sop/eop framing: drops orphan beats, closes unterminated packets, and truncates packets longer than MAX_BEATS. Output is registered with fixed 1-cycle latency and no backpressure. Optional statistics counters feed the CSR block.

## Interface
- MAX_BEATS, 1024: maximum beats per output packet, sop beat included; legal range 2..65535.
- CNT_W, 32: width of each statistics counter.
- sys_clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- in  in  avln_st  input stream from the delay FIFO: data, sop, eop, empty, valid. sop/eop are meaningful only when valid=1.
- out  out  avln_st  repaired stream.
- stats_clr  in  1  synchronous clear of all counters.
- pkt_cnt  out  CNT_W  packets emitted, counted on each output beat with eop=1.
- drop_cnt  out  CNT_W  input beats discarded.
- unterm_cnt  out  CNT_W  packets force-closed by an unexpected sop.
- trunc_cnt  out  CNT_W  packets force-closed at MAX_BEATS.

## Operation
- Internal state is IDLE, IN_PKT or DROP.
- beat_cnt is $clog2(MAX_BEATS+1) bits wide.
- Cycles with in.valid=0 change nothing except that out.valid goes to 0.
- IDLE:
  - valid & sop & eop: forward the beat unchanged; stay in IDLE.
  - valid & sop & !eop: forward the beat; beat_cnt=1; go to IN_PKT.
  - valid & !sop: drop the beat; drop_cnt++.
- IN_PKT, valid & !sop:
  - The beat is forwarded and beat_cnt++.
  - If eop=1, pass empty through and go to IDLE.
  - Else, if beat_cnt+1 == MAX_BEATS, emit the beat with eop forced to 1 and empty=0; trunc_cnt++; go to DROP.
- IN_PKT, valid & sop (the previous packet was never closed):
  - Emit this beat with sop=0, eop=1, empty=0; trunc_cnt is not incremented.
  - unterm_cnt++.
  - If the beat's own eop=1, go to IDLE; else go to DROP.
- DROP:
  - valid & !sop: drop the beat; drop_cnt++. If eop=1, go to IDLE.
  - valid & sop: resynchronise and handle the beat exactly as in IDLE, including the same next-state transition. The beat is not dropped.
- A natural eop on the MAX_BEATS-th beat is a normal packet: no truncation, trunc_cnt unchanged.
- Counters:
  - Each counter saturates at all-ones.
  - stats_clr has priority over a same-cycle increment: the counter reads 0 on the next cycle.
- out.sop and out.eop are always gated by out.valid.
- out.data and out.empty are loaded only on emitted beats; at all other times they hold their last value.

## Timing
- Latency: an input beat accepted at edge N appears on out from edge N+1. There are no bubbles and no reordering.
- Throughput: one beat per cycle. out.valid is never 1 without a corresponding in.valid one cycle earlier.
- Reset: assertion of reset_n=0 takes effect immediately, without waiting for a clock edge. Reset values:
  - state = IDLE, beat_cnt = 0.
  - out.valid, out.sop, out.eop = 0.
  - out.data, out.empty = 0.
  - all counters = 0.
- Reset mid-packet: the partial packet is abandoned. No forced eop is emitted.
- After reset deassertion, the first non-sop beat is dropped.
- Counter outputs update on the same edge as the beat that caused the increment.

## Configuration
- AVLN_FRAMER_STATS_EN defined: all four counters and stats_clr are implemented as described above.
- AVLN_FRAMER_STATS_EN undefined:
  - Counter logic is removed and all four counter ports are tied to 0.
  - stats_clr is ignored.
  - Framing and repair behaviour is unchanged.

## Test plan
- Well-formed 4-beat packet (sop on beat 0, eop on beat 3, empty=3):
  - out matches in, delayed by 1 cycle; empty=3 on the last beat.
  - pkt_cnt=1; all other counters 0.
- Two non-sop beats after reset, then a 2-beat packet:
  - The two beats do not appear on out; drop_cnt=2.
  - The 2-beat packet is emitted intact; pkt_cnt=1.
- MAX_BEATS=4, 6-beat packet:
  - Output is 4 beats, with eop=1 and empty=0 on beat 3; trunc_cnt=1.
  - Input beats 4 and 5 are dropped; drop_cnt=2.
- Packet A: sop plus 2 beats with no eop. Then packet B: sop plus 2 beats, ending in eop.
  - A's output is 4 beats, the last being B's sop beat with sop=0, eop=1.
  - B's remaining 2 beats are dropped; unterm_cnt=1, drop_cnt=2, pkt_cnt=1.
- In DROP state, a new sop & eop single-beat packet arrives:
  - It is emitted unchanged and state returns to IDLE; pkt_cnt increments.
- stats_clr asserted on the same cycle as an eop beat:
  - pkt_cnt reads 0 on the next cycle.
- Reset asserted mid-packet:
  - out.valid is 0 immediately and all counters are 0.

Source files
------------

// File: rtl/avln_framer_if.sv
// avln_st streaming bundle: data/sop/eop/empty/valid, no backpressure.
interface avln_framer_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);
  logic [DATA_W-1:0]  data;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;
  logic               valid;

  modport master (output data, sop, eop, empty, valid);
  modport slave  (input  data, sop, eop, empty, valid);
endinterface

// File: rtl/avln_framer.sv
// Framing repair stage: drops orphan beats, closes unterminated/overlong packets.
// Define AVLN_FRAMER_STATS_EN to build the pkt/drop/unterm/trunc counters.
//
// state  | meaning
// IDLE   | between packets; non-sop beats are orphans and get dropped
// IN_PKT | inside a packet; beat_cnt holds beats emitted so far
// DROP   | discarding the tail of a force-closed packet until eop or a new sop
module avln_framer #(
  parameter int MAX_BEATS = 1024,
  parameter int CNT_W     = 32,
  parameter int DATA_W    = 32,
  parameter int EMPTY_W   = 2
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  avln_framer_if.slave      in,
  avln_framer_if.master     out,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  unterm_cnt,
  output logic [CNT_W-1:0]  trunc_cnt
);

  localparam int BC_W = $clog2(MAX_BEATS + 1);
  // beat_cnt == MAX_BEATS-1 means the incoming beat is the last one allowed
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_IN_PKT, S_DROP} state_t;

  state_t             state, state_nxt;
  logic [BC_W-1:0]    beat_cnt, beat_cnt_nxt;

  logic               emit, emit_sop, emit_eop;
  logic [EMPTY_W-1:0] emit_empty;
  logic               inc_pkt, inc_drop, inc_unterm, inc_trunc;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    if (in.valid) begin
      case (state)
        S_IDLE, S_DROP: begin
          if (in.sop) begin
            if (in.eop) begin
              state_nxt = S_IDLE;
            end else begin
              state_nxt    = S_IN_PKT;
              beat_cnt_nxt = BC_W'(1);
            end
          end else if (state == S_DROP && in.eop) begin
            state_nxt = S_IDLE;
          end
        end
        S_IN_PKT: begin
          if (in.sop) begin
            beat_cnt_nxt = '0;
            state_nxt    = in.eop ? S_IDLE : S_DROP;
          end else begin
            beat_cnt_nxt = beat_cnt + BC_W'(1);
            if (in.eop)
              state_nxt = S_IDLE;
            else if (beat_cnt == BC_LAST)
              state_nxt = S_DROP;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    emit       = 1'b0;
    emit_sop   = in.sop;
    emit_eop   = in.eop;
    emit_empty = in.empty;
    inc_drop   = 1'b0;
    inc_unterm = 1'b0;
    inc_trunc  = 1'b0;
    if (in.valid) begin
      case (state)
        S_IDLE, S_DROP: begin
          if (in.sop) emit     = 1'b1;
          else        inc_drop = 1'b1;
        end
        S_IN_PKT: begin
          emit = 1'b1;
          if (in.sop) begin
            // new sop closes the open packet; the beat itself becomes its tail
            emit_sop   = 1'b0;
            emit_eop   = 1'b1;
            emit_empty = '0;
            inc_unterm = 1'b1;
          end else if (!in.eop && beat_cnt == BC_LAST) begin
            emit_eop   = 1'b1;
            emit_empty = '0;
            inc_trunc  = 1'b1;
          end
        end
        default: emit = 1'b0;
      endcase
    end
    inc_pkt = emit & emit_eop;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      out.valid <= 1'b0;
      out.sop   <= 1'b0;
      out.eop   <= 1'b0;
      out.data  <= '0;
      out.empty <= '0;
    end else begin
      out.valid <= emit;
      out.sop   <= emit & emit_sop;
      out.eop   <= emit & emit_eop;
      if (emit) begin
        out.data  <= in.data;
        out.empty <= emit_empty;
      end
    end
  end

`ifdef AVLN_FRAMER_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && c != '1) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      unterm_cnt <= '0;
      trunc_cnt  <= '0;
    end else if (stats_clr) begin
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      unterm_cnt <= '0;
      trunc_cnt  <= '0;
    end else begin
      pkt_cnt    <= sat_inc(pkt_cnt, inc_pkt);
      drop_cnt   <= sat_inc(drop_cnt, inc_drop);
      unterm_cnt <= sat_inc(unterm_cnt, inc_unterm);
      trunc_cnt  <= sat_inc(trunc_cnt, inc_trunc);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{stats_clr, inc_pkt, inc_drop, inc_unterm, inc_trunc};
  assign pkt_cnt    = '0;
  assign drop_cnt   = '0;
  assign unterm_cnt = '0;
  assign trunc_cnt  = '0;
`endif

endmodule

// File: tb/tb_avln_framer.sv
// Scoreboard bench for avln_framer with MAX_BEATS=4; counter expectations follow the stats build option.
module tb_avln_framer;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stats_clr = 1'b0;
  logic [31:0] pkt_cnt, drop_cnt, unterm_cnt, trunc_cnt;

  avln_framer_if #(.DATA_W(32), .EMPTY_W(2)) in_if ();
  avln_framer_if #(.DATA_W(32), .EMPTY_W(2)) out_if ();

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  always #5 sys_clk = ~sys_clk;

  avln_framer #(.MAX_BEATS(4), .CNT_W(32), .DATA_W(32), .EMPTY_W(2)) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .in         (in_if),
    .out        (out_if),
    .stats_clr  (stats_clr),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt),
    .unterm_cnt (unterm_cnt),
    .trunc_cnt  (trunc_cnt)
  );

  function automatic logic [31:0] ec(input int v);
`ifdef AVLN_FRAMER_STATS_EN
    return 32'(v);
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cnts(input string tag, input int p, input int d, input int u, input int t);
    chk({tag, ".pkt_cnt"},    pkt_cnt,    ec(p));
    chk({tag, ".drop_cnt"},   drop_cnt,   ec(d));
    chk({tag, ".unterm_cnt"}, unterm_cnt, ec(u));
    chk({tag, ".trunc_cnt"},  trunc_cnt,  ec(t));
  endtask

  always @(negedge sys_clk) begin
    beat_t e;
    if (reset_n === 1'b1) begin
      checks++;
      if (out_if.valid === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%h sop=%b eop=%b with nothing expected",
                   out_if.data, out_if.sop, out_if.eop);
        end else begin
          e = sb.pop_front();
          if (out_if.data !== e.data || out_if.sop !== e.sop ||
              out_if.eop !== e.eop || out_if.empty !== e.empty) begin
            errors++;
            $display("FAIL beat: got data=%h sop=%b eop=%b empty=%0d expected data=%h sop=%b eop=%b empty=%0d",
                     out_if.data, out_if.sop, out_if.eop, out_if.empty,
                     e.data, e.sop, e.eop, e.empty);
          end
        end
      end else if (out_if.valid !== 1'b0 || out_if.sop !== 1'b0 || out_if.eop !== 1'b0) begin
        errors++;
        $display("FAIL idle_gating: got valid=%b sop=%b eop=%b expected all 0",
                 out_if.valid, out_if.sop, out_if.eop);
      end
    end
  end

  task automatic drive(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
    @(posedge sys_clk); #1;
    stats_clr    = 1'b0;
    in_if.valid  = 1'b1;
    in_if.data   = d;
    in_if.sop    = s;
    in_if.eop    = e;
    in_if.empty  = emp;
  endtask

  task automatic fw(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
    drive(d, s, e, emp);
    sb.push_back('{d, s, e, emp});
  endtask

  task automatic dr(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
    drive(d, s, e, emp);
  endtask

  task automatic fx(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp,
                    input logic xs, input logic xe, input logic [1:0] xemp);
    drive(d, s, e, emp);
    sb.push_back('{d, xs, xe, xemp});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
      in_if.valid = 1'b0;
      stats_clr   = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1;
    in_if.valid = 1'b0;
    reset_n     = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    in_if.valid = 1'b0;
    in_if.data  = '0;
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
    in_if.empty = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst.valid", {31'd0, out_if.valid}, 32'd0);
    chk("rst.sop_eop", {30'd0, out_if.sop, out_if.eop}, 32'd0);
    chk("rst.data", out_if.data, 32'd0);
    chk("rst.empty", {30'd0, out_if.empty}, 32'd0);
    chk_cnts("rst", 0, 0, 0, 0);
    reset_n = 1'b1;

    // well-formed 4-beat packet, natural eop on the MAX_BEATS-th beat
    fw(32'hA000_0000, 1, 0, 0);
    fw(32'hA000_0001, 0, 0, 0);
    fw(32'hA000_0002, 0, 0, 0);
    fw(32'hA000_0003, 0, 1, 3);
    idle(2);
    chk_cnts("s1", 1, 0, 0, 0);

    // orphans after reset, then a 2-beat packet
    do_reset();
    dr(32'hB000_0000, 0, 0, 1);
    dr(32'hB000_0001, 0, 1, 2);
    fw(32'hB000_0002, 1, 0, 0);
    fw(32'hB000_0003, 0, 1, 1);
    idle(2);
    chk_cnts("s2", 1, 2, 0, 0);

    // 6-beat packet truncated at 4 beats
    do_reset();
    fw(32'hC000_0000, 1, 0, 0);
    fw(32'hC000_0001, 0, 0, 0);
    fw(32'hC000_0002, 0, 0, 0);
    fx(32'hC000_0003, 0, 0, 2, 0, 1, 0);
    dr(32'hC000_0004, 0, 0, 0);
    dr(32'hC000_0005, 0, 1, 1);
    idle(2);
    chk_cnts("s3", 1, 2, 0, 1);

    // unterminated packet closed by the next sop
    do_reset();
    fw(32'hD000_0000, 1, 0, 0);
    fw(32'hD000_0001, 0, 0, 0);
    fw(32'hD000_0002, 0, 0, 0);
    fx(32'hE000_0000, 1, 0, 1, 0, 1, 0);
    dr(32'hE000_0001, 0, 0, 0);
    dr(32'hE000_0002, 0, 1, 2);
    idle(2);
    chk_cnts("s4", 1, 2, 1, 0);

    // truncation with idle gaps, then sop&eop resync out of DROP
    do_reset();
    fw(32'hF000_0000, 1, 0, 0);
    idle(1);
    fw(32'hF000_0001, 0, 0, 0);
    idle(2);
    fw(32'hF000_0002, 0, 0, 0);
    fx(32'hF000_0003, 0, 0, 0, 0, 1, 0);
    fw(32'h6000_0000, 1, 1, 2);
    dr(32'h6000_0001, 0, 0, 0);
    fw(32'h7000_0000, 1, 0, 0);
    fw(32'h7000_0001, 0, 1, 1);
    idle(2);
    chk_cnts("s5", 3, 1, 0, 1);

    // stats_clr on the same cycle as an eop beat
    do_reset();
    fw(32'h8000_0000, 1, 1, 0);
    idle(1);
    chk("s6.pkt_before", pkt_cnt, ec(1));
    fw(32'h8000_0001, 1, 0, 0);
    fw(32'h8000_0002, 0, 1, 3);
    stats_clr = 1'b1;
    idle(1);
    chk("s6.pkt_cleared", pkt_cnt, ec(0));
    idle(1);
    fw(32'h8000_0003, 1, 1, 1);
    idle(2);
    chk("s6.pkt_after", pkt_cnt, ec(1));

    // asynchronous reset in the middle of a packet
    fw(32'h9000_0000, 1, 0, 0);
    fw(32'h9000_0001, 0, 0, 0);
    @(posedge sys_clk); #1;
    in_if.valid = 1'b0;
    @(negedge sys_clk); #1;
    chk("s7.valid_pre", {31'd0, out_if.valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("s7.valid_async", {31'd0, out_if.valid}, 32'd0);
    chk_cnts("s7.rst", 0, 0, 0, 0);
    repeat (2) @(posedge sys_clk);
    #1 reset_n = 1'b1;
    dr(32'h9000_0002, 0, 1, 0);
    idle(3);
    chk_cnts("s7.post", 0, 1, 0, 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
